// File: rtl/status_led_pwm_pkg.sv
// Shared types for the status-LED PWM controller.
package status_led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        OFF     = 2'd0,
        SOLID   = 2'd1,
        BLINK   = 2'd2,
        BREATHE = 2'd3
    } led_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } ramp_dir_t;

endpackage

// File: rtl/status_led_pwm_if.sv
// Host-side channel configuration port of the status-LED PWM controller.
interface status_led_pwm_if #(
    parameter int PWM_WIDTH = 8
);
    import status_led_pkg::*;

    logic                 cfg_wr;
    logic [2:0]           cfg_ch;
    logic [MODE_W-1:0]    cfg_mode;
    logic [PWM_WIDTH-1:0] cfg_level;

    modport master (output cfg_wr, cfg_ch, cfg_mode, cfg_level);
    modport slave  (input  cfg_wr, cfg_ch, cfg_mode, cfg_level);

endinterface

// File: rtl/status_led_pwm_chan.sv
// One LED channel: selects the period duty from mode/level and drives the registered PWM bit.
module status_led_chan
    import status_led_pkg::*;
#(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  led_mode_t            i_mode,
    input  logic [PWM_WIDTH-1:0] i_level,
    input  logic                 i_phase,
    input  logic [PWM_WIDTH-1:0] i_ramp,
    input  logic [PWM_WIDTH-1:0] i_pwm_cnt,
    output logic                 o_pwm
);

    logic [PWM_WIDTH-1:0] w_duty;

    always_comb begin
        w_duty = '0;
        unique case (i_mode)
            OFF:     w_duty = '0;
            SOLID:   w_duty = i_level;
            BLINK:   w_duty = i_phase ? i_level : '0;
            BREATHE: w_duty = (i_ramp < i_level) ? i_ramp : i_level;
            default: w_duty = '0;
        endcase
    end

    // Full-scale duty is forced high so the output has no one-tick gap per period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pwm <= 1'b0;
        end else begin
            o_pwm <= (w_duty == '1) ? 1'b1 : (i_pwm_cnt < w_duty);
        end
    end

endmodule

// File: rtl/status_led_pwm.sv
// N-channel status-LED PWM controller: shared timebase, blink and breathe generators,
// shadowed channel config applied at PWM period boundaries.
module status_led_pwm
    import status_led_pkg::*;
#(
    parameter int CHANNELS      = 3,
    parameter int PWM_WIDTH     = 8,
    parameter int PRESCALE      = 47,
    parameter int BLINK_PERIODS = 64,
    parameter int BREATHE_STEP  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    status_led_pwm_if.slave     cfg,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                led_en,
    output logic                period_start
);

    localparam int PRE_W = (PRESCALE > 0)      ? $clog2(PRESCALE + 1)   : 1;
    localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS)  : 1;
    localparam int STP_W = (BREATHE_STEP > 1)  ? $clog2(BREATHE_STEP)   : 1;

    logic [PRE_W-1:0]     r_pre;
    logic [PWM_WIDTH-1:0] r_pwm_cnt;
    logic [BLK_W-1:0]     r_blink_cnt;
    logic                 r_phase;
    logic [STP_W-1:0]     r_step_cnt;
    logic [PWM_WIDTH-1:0] r_ramp;
    ramp_dir_t            r_dir;
    logic                 r_period_start;
    logic                 r_led_en;

    led_mode_t            r_sh_mode   [CHANNELS];
    logic [PWM_WIDTH-1:0] r_sh_level  [CHANNELS];
    led_mode_t            r_act_mode  [CHANNELS];
    logic [PWM_WIDTH-1:0] r_act_level [CHANNELS];

    logic w_tick;
    logic w_boundary;
    logic w_step;
    logic w_any_on;

    assign w_tick     = (r_pre == PRE_W'(PRESCALE));
    assign w_boundary = w_tick && (r_pwm_cnt == '1);
    assign w_step     = w_boundary && (r_step_cnt == STP_W'(BREATHE_STEP - 1));

    // Looks at shadow so led_en switches on the same edge that loads active.
    always_comb begin
        w_any_on = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_sh_mode[i] != OFF) w_any_on = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre          <= '0;
            r_pwm_cnt      <= '0;
            r_blink_cnt    <= '0;
            r_phase        <= 1'b0;
            r_step_cnt     <= '0;
            r_ramp         <= '0;
            r_dir          <= DIR_UP;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_boundary;
            if (w_tick) begin
                r_pre     <= '0;
                r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
            end else begin
                r_pre     <= r_pre + PRE_W'(1);
            end
            if (w_boundary) begin
                if (r_blink_cnt == BLK_W'(BLINK_PERIODS - 1)) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BLK_W'(1);
                end
                r_step_cnt <= w_step ? '0 : r_step_cnt + STP_W'(1);
            end
            // Reaching an endpoint only flips direction, so the endpoint lasts two steps.
            if (w_step) begin
                if (r_dir == DIR_UP) begin
                    if (r_ramp == '1) r_dir  <= DIR_DOWN;
                    else              r_ramp <= r_ramp + PWM_WIDTH'(1);
                end else begin
                    if (r_ramp == '0) r_dir  <= DIR_UP;
                    else              r_ramp <= r_ramp - PWM_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_sh_mode[i]   <= OFF;
                r_sh_level[i]  <= '0;
                r_act_mode[i]  <= OFF;
                r_act_level[i] <= '0;
            end
            r_led_en <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg.cfg_wr && (cfg.cfg_ch == 3'(i))) begin
                    r_sh_mode[i]  <= led_mode_t'(cfg.cfg_mode);
                    r_sh_level[i] <= cfg.cfg_level;
                end
                if (w_boundary) begin
                    r_act_mode[i]  <= r_sh_mode[i];
                    r_act_level[i] <= r_sh_level[i];
                end
            end
            if (w_boundary) r_led_en <= w_any_on;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        status_led_chan #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_mode    (r_act_mode[g]),
            .i_level   (r_act_level[g]),
            .i_phase   (r_phase),
            .i_ramp    (r_ramp),
            .i_pwm_cnt (r_pwm_cnt),
            .o_pwm     (pwm_out[g])
        );
    end

    assign led_en       = r_led_en;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_status_led_pwm.sv
// Directed bench for status_led_pwm with a 16-tick period and one tick per clock.
module tb_status_led_pwm;

    localparam int CH = 3;
    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] pwm_out;
    logic          led_en;
    logic          period_start;

    int checks = 0;
    int errors = 0;
    int hc[CH];

    typedef struct {
        int         ch;
        logic [1:0] mode;
        logic [3:0] level;
        bit         pre_chk;
        bit         pre_pwm;
        bit         pre_led;
        int         exp_high;
        bit         exp_led;
    } vec_t;

    vec_t vecs[7];
    int   blink_exp[8] = '{0, 4, 4, 0, 0, 4, 4, 0};

    status_led_pwm_if #(.PWM_WIDTH(PW)) cfg_if ();

    status_led_pwm #(
        .CHANNELS      (CH),
        .PWM_WIDTH     (PW),
        .PRESCALE      (0),
        .BLINK_PERIODS (2),
        .BREATHE_STEP  (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg          (cfg_if),
        .pwm_out      (pwm_out),
        .led_en       (led_en),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input logic [1:0] mode, input logic [3:0] lvl);
        cfg_if.cfg_ch    = 3'(ch);
        cfg_if.cfg_mode  = mode;
        cfg_if.cfg_level = lvl;
        cfg_if.cfg_wr    = 1'b1;
        @(negedge clk);
        cfg_if.cfg_wr    = 1'b0;
    endtask

    task automatic wait_period_start();
        int n = 0;
        while (period_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (period_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL period_start_timeout: got no pulse, expected one within 40 cycles");
        end
    endtask

    // Samples the 16 output values belonging to the period that starts at the next pulse.
    task automatic measure_period();
        wait_period_start();
        for (int c = 0; c < CH; c++) hc[c] = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) hc[c] += int'(pwm_out[c]);
        end
    endtask

    function automatic int exp_ramp(input int b);
        int r;
        r = b % 32;
        if (r == 0)       return 0;
        else if (r <= 15) return r;
        else if (r == 16) return 15;
        else              return 31 - r;
    endfunction

    initial begin
        int n;
        bit ok;
        int r;

        vecs[0] = '{1, 2'd1, 4'd15, 1'b1, 1'b0, 1'b0, 16, 1'b1};
        vecs[1] = '{1, 2'd1, 4'd0,  1'b1, 1'b1, 1'b1, 0,  1'b1};
        vecs[2] = '{1, 2'd0, 4'd7,  1'b1, 1'b0, 1'b1, 0,  1'b0};
        vecs[3] = '{0, 2'd1, 4'd8,  1'b1, 1'b0, 1'b0, 8,  1'b1};
        vecs[4] = '{2, 2'd1, 4'd1,  1'b1, 1'b0, 1'b1, 1,  1'b1};
        vecs[5] = '{2, 2'd1, 4'd14, 1'b0, 1'b0, 1'b0, 14, 1'b1};
        vecs[6] = '{2, 2'd0, 4'd0,  1'b0, 1'b0, 1'b0, 0,  1'b1};

        cfg_if.cfg_wr    = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_mode  = '0;
        cfg_if.cfg_level = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_led_en", int'(led_en), 0);
        check("rst_period_start", int'(period_start), 0);
        rst_n = 1'b1;

        // Pulse is one cycle wide and recurs every 16 clocks.
        wait_period_start();
        @(negedge clk);
        check("ps_width", int'(period_start), 0);
        n = 1;
        while (period_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ps_spacing", n, 16);

        for (int v = 0; v < 7; v++) begin
            cfg_write(vecs[v].ch, vecs[v].mode, vecs[v].level);
            ok = 1'b1;
            n = 0;
            while (period_start !== 1'b1 && n < 40) begin
                if (pwm_out[vecs[v].ch] !== vecs[v].pre_pwm || led_en !== vecs[v].pre_led) ok = 1'b0;
                @(negedge clk);
                n++;
            end
            if (vecs[v].pre_chk) check($sformatf("vec%0d_hold_until_boundary", v), int'(ok), 1);
            wait_period_start();
            check($sformatf("vec%0d_led_en", v), int'(led_en), int'(vecs[v].exp_led));
            measure_period();
            check($sformatf("vec%0d_high_count", v), hc[vecs[v].ch], vecs[v].exp_high);
        end

        // Out-of-range channel index must not touch any channel.
        cfg_write(5, 2'd1, 4'd15);
        measure_period();
        check("bad_ch_ch0", hc[0], 8);
        check("bad_ch_ch1", hc[1], 0);
        check("bad_ch_ch2", hc[2], 0);

        // Write landing on the boundary edge waits one extra period.
        repeat (15) @(negedge clk);
        check("pre_boundary_ps_low", int'(period_start), 0);
        cfg_write(1, 2'd1, 4'd15);
        measure_period();
        check("bnd_write_deferred", hc[1], 0);
        measure_period();
        check("bnd_write_applied", hc[1], 16);
        check("bnd_write_ch0", hc[0], 8);

        // Asynchronous reset clears outputs between clock edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm_out", int'(pwm_out), 0);
        check("async_rst_led_en", int'(led_en), 0);
        check("async_rst_period_start", int'(period_start), 0);
        @(negedge clk);
        rst_n = 1'b1;

        cfg_write(2, 2'd2, 4'd4);
        for (int b = 0; b < 8; b++) begin
            measure_period();
            check($sformatf("blink_p%0d", b + 1), hc[2], blink_exp[b]);
        end

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cfg_write(0, 2'd3, 4'd10);
        cfg_write(1, 2'd3, 4'd15);
        for (int b = 1; b <= 34; b++) begin
            measure_period();
            r = exp_ramp(b);
            check($sformatf("breathe10_p%0d", b), hc[0], (r < 10) ? r : 10);
            check($sformatf("breathe15_p%0d", b), hc[1], (r == 15) ? 16 : r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
